// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states, default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    // Opcodes 0xx are the iterative MUL/DIV group; bit 1 selects divide, bit 0 signed.
    function automatic logic is_arith(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface mdu_hilo_if #(parameter int WIDTH = mdu_pkg::MDU_WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, HI, LO);

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y = neg ? -x : x. Used for magnitudes and sign fix-up.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO result registers and MTHI/MTLO writes.
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
// S_FIX  | sign correction, HI/LO written
// S_DONE | done pulse; may accept the next op directly
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    mdu_hilo_if.slave bus
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               is_div;
    logic               sign_res;
    logic               sign_a;
    logic               div_zero;
    logic               busy;
    logic               done;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    mdu_negate #(.WIDTH(WIDTH)) u_mag_a (.x(bus.A), .neg(bus.op[0] & bus.A[WIDTH-1]), .y(a_mag));
    mdu_negate #(.WIDTH(WIDTH)) u_mag_b (.x(bus.B), .neg(bus.op[0] & bus.B[WIDTH-1]), .y(b_mag));

    // Multiplier shifts out of acc low half; multiplicand is added into the high half.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Partial remainder lives in acc high half; dividend bits shift up out of the low half.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.x(acc), .neg(sign_res), .y(prod_fix));
    mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (.x(acc[WIDTH-1:0]), .neg(sign_res), .y(quo_fix));
    mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (.x(acc[2*WIDTH-1:WIDTH]), .neg(sign_a), .y(rem_fix));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            sign_res <= 1'b0;
            sign_a   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (bus.start) begin
                        if (bus.op == OP_MTHI) begin
                            hi <= bus.A;
                        end else if (bus.op == OP_MTLO) begin
                            lo <= bus.A;
                        end else if (is_arith(bus.op)) begin
                            state    <= S_RUN;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            is_div   <= bus.op[1];
                            sign_res <= bus.op[0] & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            sign_a   <= bus.op[0] & bus.A[WIDTH-1];
                            div_zero <= bus.op[1] & (bus.B == '0);
                            a_raw    <= bus.A;
                            if (bus.op[1]) begin
                                acc  <= {{WIDTH{1'b0}}, a_mag};
                                opnd <= b_mag;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, b_mag};
                                opnd <= a_mag;
                            end
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        acc <= {(div_ok ? div_diff : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ok};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                    if (div_zero) begin
                        lo <= '1;
                        hi <= a_raw;
                    end else if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vectors, random ops against an arithmetic model,
// control scenarios (busy start, MTHI/MTLO, no-op, back-to-back, reset abort).
module tb_mdu_hilo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_hilo_if #(.WIDTH(32)) bus ();

    mdu_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic with the unit's special cases.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        hi = '0;
        lo = '0;
        case (op)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'b001: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'b010: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
            end
        endcase
    endfunction

    // Drives one request; lat counts rising edges from the accepting edge through the
    // edge after which done is seen (-1 if it never arrives).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        busy0     = bus.busy;
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        lat       = -1;
        for (int n = 2; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", bus.LO); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b010, 3'b011, 3'b011, 3'b001};
        logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5,
                                  32'h8000_0000, 32'd7, 32'h8000_0000};
        logic [31:0] t_b  [8] = '{32'h2, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        logic [31:0] t_hi [8] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'h0, 32'd7,
                                  32'h4000_0000};
        logic [31:0] t_lo [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        int   lat;
        logic busy0;
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, busy0);
            n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy: got %b want 1", i, busy0); end
            n_cmp++; if (lat != 34) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 34", i, lat); end
            n_cmp++; if (bus.HI !== t_hi[i]) begin n_err++; $display("FAIL dir%0d_hi: got %h want %h", i, bus.HI, t_hi[i]); end
            n_cmp++; if (bus.LO !== t_lo[i]) begin n_err++; $display("FAIL dir%0d_lo: got %h want %h", i, bus.LO, t_lo[i]); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width: got %b want 0", i, bus.done); end
            exp_hi = t_hi[i];
            exp_lo = t_lo[i];
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_v [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] a, b, mh, ml;
        logic [2:0]  op;
        int   lat;
        logic busy0;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       begin a = $urandom; b = $urandom; end
                1:       begin a = $urandom; b = 32'($urandom_range(0, 300)); end
                default: begin a = edge_v[$urandom_range(0, 4)]; b = edge_v[$urandom_range(0, 4)]; end
            endcase
            model(op, a, b, mh, ml);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(op, a, b, lat, busy0);
            n_cmp++; if (lat != 34) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 34", i, lat); end
            n_cmp++; if (bus.HI !== mh) begin n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.HI, mh); end
            n_cmp++; if (bus.LO !== ml) begin n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.LO, ml); end
            exp_hi = mh;
            exp_lo = ml;
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] mh, ml;
        int   lat;
        model(3'b001, 32'hFFFF_0123, 32'h0000_7777, mh, ml);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b001; bus.A = 32'hFFFF_0123; bus.B = 32'h0000_7777;
        @(posedge clk);
        #1;
        lat = -1;
        for (int n = 2; n <= 60; n++) begin
            if (n >= 3 && n <= 20) begin
                bus.start = 1'b1; bus.op = 3'($urandom_range(0, 5)); bus.A = $urandom; bus.B = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (n == 20) begin
                n_cmp++; if (bus.HI !== exp_hi) begin n_err++; $display("FAIL busy_hi_hold: got %h want %h", bus.HI, exp_hi); end
                n_cmp++; if (bus.LO !== exp_lo) begin n_err++; $display("FAIL busy_lo_hold: got %h want %h", bus.LO, exp_lo); end
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL busy_latency: got %0d want 34", lat); end
        n_cmp++; if (bus.HI !== mh) begin n_err++; $display("FAIL busy_result_hi: got %h want %h", bus.HI, mh); end
        n_cmp++; if (bus.LO !== ml) begin n_err++; $display("FAIL busy_result_lo: got %h want %h", bus.LO, ml); end
        exp_hi = mh;
        exp_lo = ml;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_no_rerun: got %b want 0", bus.busy); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'h1234;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.LO !== 32'h1234) begin n_err++; $display("FAIL mtlo_lo: got %h want 00001234", bus.LO); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.HI !== exp_hi) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want %h", bus.HI, exp_hi); end
        exp_lo = 32'h1234;
        @(negedge clk);
        bus.op = 3'b100; bus.A = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.HI !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mthi_hi: got %h want cafef00d", bus.HI); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mthi_done: got %b want 0", bus.done); end
        exp_hi = 32'hCAFE_F00D;
        @(negedge clk);
        bus.op = 3'b110 | 3'($urandom_range(0, 1)); bus.A = $urandom; bus.B = $urandom;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL noop_busy: got %b want 0", bus.busy); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL noop_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.HI !== exp_hi) begin n_err++; $display("FAIL noop_hi: got %h want %h", bus.HI, exp_hi); end
        n_cmp++; if (bus.LO !== exp_lo) begin n_err++; $display("FAIL noop_lo: got %h want %h", bus.LO, exp_lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mh, ml;
        int   lat;
        logic busy0;
        run_op(3'b010, 32'd1000, 32'd33, lat, busy0);
        model(3'b011, 32'hFFFF_FC18, 32'd33, mh, ml);
        run_op(3'b011, 32'hFFFF_FC18, 32'd33, lat, busy0);
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy0); end
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL b2b_latency: got %0d want 34", lat); end
        n_cmp++; if (bus.HI !== mh) begin n_err++; $display("FAIL b2b_hi: got %h want %h", bus.HI, mh); end
        n_cmp++; if (bus.LO !== ml) begin n_err++; $display("FAIL b2b_lo: got %h want %h", bus.LO, ml); end
    endtask

    task automatic test_reset_abort();
        logic seen_done;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL abort_hi: got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL abort_lo: got %h want 0", bus.LO); end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
